best_match_tracker: RTL

Consumer side of the motion-estimation search controller: takes the per-PE distortion results that the controller flags with `comp_start`/`pe_ready`, keeps the running minimum over all candidate displacements, and reports the winning motion vector. It sits after the PE array and before the vector output register stage. It runs one search per `start` assertion.

---
 rtl/me_pkg.sv | 25 ++
 rtl/best_match_tracker_if.sv | 28 ++
 rtl/pe_dist_select.sv | 26 ++
 rtl/best_match_tracker.sv | 121 ++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants, state type and vector magnitude helper for best_match_tracker
package me_pkg;

    localparam int NUM_PE   = 16;
    localparam int DIST_W   = 16;
    localparam int VEC_W    = 4;
    localparam int NUM_CAND = 256;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } bmt_state_t;

    // |x|+|y| of two's-complement components; one extra bit so -8 and the sum both fit
    function automatic logic [VEC_W:0] vec_mag(input logic [VEC_W-1:0] x,
                                               input logic [VEC_W-1:0] y);
        logic [VEC_W:0] ax;
        logic [VEC_W:0] ay;
        ax = x[VEC_W-1] ? ({1'b0, ~x} + 1'b1) : {1'b0, x};
        ay = y[VEC_W-1] ? ({1'b0, ~y} + 1'b1) : {1'b0, y};
        return ax + ay;
    endfunction

endpackage

// File: rtl/best_match_tracker_if.sv
// rtl/best_match_tracker_if.sv - PE result / search control / result bundle for best_match_tracker
interface best_match_tracker_if #(
    parameter int NUM_PE = me_pkg::NUM_PE,
    parameter int DIST_W = me_pkg::DIST_W,
    parameter int VEC_W  = me_pkg::VEC_W
);
    logic                     start;
    logic                     comp_start;
    logic [NUM_PE-1:0]        pe_ready;
    logic [NUM_PE*DIST_W-1:0] pe_dist;
    logic [VEC_W-1:0]         vector_x;
    logic [VEC_W-1:0]         vector_y;
    logic                     done;
    logic [DIST_W-1:0]        best_dist;
    logic [VEC_W-1:0]         motion_x;
    logic [VEC_W-1:0]         motion_y;
    logic                     multi_hot_err;

    modport master (
        output start, comp_start, pe_ready, pe_dist, vector_x, vector_y,
        input  done, best_dist, motion_x, motion_y, multi_hot_err
    );

    modport slave (
        input  start, comp_start, pe_ready, pe_dist, vector_x, vector_y,
        output done, best_dist, motion_x, motion_y, multi_hot_err
    );
endinterface

// File: rtl/pe_dist_select.sv
// rtl/pe_dist_select.sv - lowest-index-wins selection of one PE distortion from the ready flags
module pe_dist_select #(
    parameter int NUM_PE = me_pkg::NUM_PE,
    parameter int DIST_W = me_pkg::DIST_W
) (
    input  logic [NUM_PE-1:0]        pe_ready,
    input  logic [NUM_PE*DIST_W-1:0] pe_dist,
    output logic [DIST_W-1:0]        sel_dist,
    output logic                     sel_valid,
    output logic                     multi_hot
);

    // Scan from the top so the lowest set index is the last assignment and wins
    always_comb begin
        sel_dist = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (pe_ready[i]) begin
                sel_dist = pe_dist[i*DIST_W +: DIST_W];
            end
        end
    end

    assign sel_valid = |pe_ready;
    assign multi_hot = |(pe_ready & (pe_ready - NUM_PE'(1)));

endmodule

// File: rtl/best_match_tracker.sv
// rtl/best_match_tracker.sv - running-minimum SAD tracker with search FSM; optional BMT_ZERO_BIAS_EN tie-break
module best_match_tracker #(
    parameter int NUM_PE   = me_pkg::NUM_PE,
    parameter int DIST_W   = me_pkg::DIST_W,
    parameter int VEC_W    = me_pkg::VEC_W,
    parameter int NUM_CAND = me_pkg::NUM_CAND
) (
    input  logic                 clock,
    input  logic                 reset_n,
    best_match_tracker_if.slave  bus
);
    import me_pkg::*;

    localparam int                CNT_W    = $clog2(NUM_CAND) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_CAND - 1);

    bmt_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIST_W-1:0] best_q, best_d;
    logic [VEC_W-1:0]  mx_q, mx_d;
    logic [VEC_W-1:0]  my_q, my_d;
    logic              err_q, err_d;

    logic [DIST_W-1:0] sel_dist;
    logic              sel_valid;
    logic              multi_hot;
    logic              accept;
    logic              better;

    pe_dist_select #(
        .NUM_PE (NUM_PE),
        .DIST_W (DIST_W)
    ) u_sel (
        .pe_ready  (bus.pe_ready),
        .pe_dist   (bus.pe_dist),
        .sel_dist  (sel_dist),
        .sel_valid (sel_valid),
        .multi_hot (multi_hot)
    );

    // An abort (start low) in SEARCH takes priority over a candidate in the same cycle
    assign accept = (state_q == SEARCH) && bus.start && bus.comp_start && sel_valid;

`ifdef BMT_ZERO_BIAS_EN
    assign better = (sel_dist < best_q) ||
                    ((sel_dist == best_q) &&
                     (vec_mag(bus.vector_x, bus.vector_y) < vec_mag(mx_q, my_q)));
`else
    assign better = (sel_dist < best_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        mx_d    = mx_q;
        my_d    = my_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                    best_d  = '1;
                    mx_d    = '0;
                    my_d    = '0;
                    err_d   = 1'b0;
                end
            end
            SEARCH: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (multi_hot) begin
                        err_d = 1'b1;
                    end
                    if (better) begin
                        best_d = sel_dist;
                        mx_d   = bus.vector_x;
                        my_d   = bus.vector_y;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            best_q  <= '1;
            mx_q    <= '0;
            my_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            err_q   <= err_d;
        end
    end

    assign bus.done          = (state_q == DONE);
    assign bus.best_dist     = best_q;
    assign bus.motion_x      = mx_q;
    assign bus.motion_y      = my_q;
    assign bus.multi_hot_err = err_q;

endmodule
